rib_s7_bridge: RTL

//  Slave-7 endpoint of the RIB bus: turns the combinational req/ack access from the bus into a

---
 rtl/rib_s7_bridge_pkg.sv | 16 +
 rtl/rib_bridge_timer.sv | 36 +++
 rtl/rib_s7_bridge.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rib_s7_bridge_pkg.sv
// Shared constants and FSM encoding for the RIB slave-7 external-bus bridge.
package rib_s7_bridge_pkg;

    localparam logic [31:0] ZeroWord        = 32'h0000_0000;
    localparam logic        WriteEnable     = 1'b1;
    localparam int unsigned TmoLimitDefault = 200;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StCmd  = 3'd1,
        StResp = 3'd2,
        StAck  = 3'd3,
        StTurn = 3'd4
    } bridge_state_e;

endpackage

// File: rtl/rib_bridge_timer.sv
// Saturating watchdog counter; expired_o flags the last allowed cycle of an access.
module rib_bridge_timer
    import rib_s7_bridge_pkg::*;
#(
    parameter int unsigned TMO_W     = 8,
    parameter int unsigned TMO_LIMIT = TmoLimitDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {TMO_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == TMO_W'(TMO_LIMIT - 1));

endmodule

// File: rtl/rib_s7_bridge.sv
// RIB slave-7 endpoint: converts a held req/ack access into a registered valid/ready
// external transaction, with a watchdog that forces completion of hung accesses.
module rib_s7_bridge
    import rib_s7_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TMO_W     = 8,
    parameter int unsigned TMO_LIMIT = TmoLimitDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              we_i,
    input  logic              req_i,
    output logic [DATA_W-1:0] data_o,
    output logic              ack_o,
    output logic [ADDR_W-1:0] ext_addr_o,
    output logic [DATA_W-1:0] ext_wdata_o,
    output logic              ext_we_o,
    output logic              ext_valid_o,
    input  logic              ext_ready_i,
    input  logic [DATA_W-1:0] ext_rdata_i,
    input  logic              ext_rvalid_i,
    output logic              timeout_o
);

    bridge_state_e     state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
    logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
    logic              ext_we_q, ext_we_d;
    logic              ext_valid_q, ext_valid_d;
    logic              timeout_q, timeout_d;
    logic              expired;
    logic              is_write;

    rib_bridge_timer #(
        .TMO_W     (TMO_W),
        .TMO_LIMIT (TMO_LIMIT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == StIdle),
        .en_i      ((state_q == StCmd) || (state_q == StResp)),
        .expired_o (expired)
    );

    assign is_write = (ext_we_q == WriteEnable);

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        ext_we_d    = ext_we_q;
        ext_valid_d = ext_valid_q;
        timeout_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_i) begin
                    ext_addr_d  = addr_i;
                    ext_wdata_d = data_i;
                    ext_we_d    = we_i;
                    ext_valid_d = 1'b1;
                    state_d     = StCmd;
                end
            end
            StCmd: begin
                // Real completion beats the watchdog when both land in the same cycle.
                if (ext_ready_i && (is_write || ext_rvalid_i)) begin
                    ext_valid_d = 1'b0;
                    if (!is_write) begin
                        data_d = ext_rdata_i;
                    end
                    state_d = StAck;
                end else if (expired) begin
                    ext_valid_d = 1'b0;
                    data_d      = DATA_W'(ZeroWord);
                    timeout_d   = 1'b1;
                    state_d     = StAck;
                end else if (ext_ready_i) begin
                    ext_valid_d = 1'b0;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (ext_rvalid_i) begin
                    data_d  = ext_rdata_i;
                    state_d = StAck;
                end else if (expired) begin
                    data_d    = DATA_W'(ZeroWord);
                    timeout_d = 1'b1;
                    state_d   = StAck;
                end
            end
            StAck:   state_d = StTurn;
            // Dead cycle so a req still held from this access is not re-sampled.
            StTurn:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            data_q      <= '0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_we_q    <= 1'b0;
            ext_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            ext_we_q    <= ext_we_d;
            ext_valid_q <= ext_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign data_o      = data_q;
    assign ack_o       = (state_q == StAck);
    assign ext_addr_o  = ext_addr_q;
    assign ext_wdata_o = ext_wdata_q;
    assign ext_we_o    = ext_we_q;
    assign ext_valid_o = ext_valid_q;
    assign timeout_o   = timeout_q;

endmodule
